// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and its line front end.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_A,
    PTR,
    ACK_P,
    WDATA,
    ACK_W,
    RDATA,
    MACK,
    IGNORE
  } state_t;

  localparam logic [6:0] CAM_ADDR = 7'h58;

endpackage

// File: rtl/i2c_target_if.sv
// Pad, host-preload and bus-write-report signals of the I2C target.
interface i2c_target_if #(
  parameter int PTR_W = 6
);
  logic             scl_in;
  logic             sda_in;
  logic             sda_oe;
  logic             host_we;
  logic [PTR_W-1:0] host_addr;
  logic [7:0]       host_wdata;
  logic             bus_wr;
  logic [PTR_W-1:0] bus_wr_addr;
  logic [7:0]       bus_wr_data;
  logic             busy;

  modport slave (
    input  scl_in, sda_in, host_we, host_addr, host_wdata,
    output sda_oe, bus_wr, bus_wr_addr, bus_wr_data, busy
  );

  modport master (
    output scl_in, sda_in, host_we, host_addr, host_wdata,
    input  sda_oe, bus_wr, bus_wr_addr, bus_wr_data, busy
  );
endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with one history flop per line; flags SCL edges,
// START and STOP from the synchronised values.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [1:0] pad;
  logic [1:0] now_s;
  logic [1:0] old_s;

  assign pad = {sda_in, scl_in};

  // Index 0 is SCL, index 1 is SDA; idle bus is high on both.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [2:0] pipe_reg;
      always_ff @(posedge clk) begin
        if (!reset) pipe_reg <= 3'b111;
        else        pipe_reg <= {pipe_reg[1:0], pad[gi]};
      end
      assign now_s[gi] = pipe_reg[1];
      assign old_s[gi] = pipe_reg[2];
    end
  endgenerate

  assign sda      = now_s[1];
  assign scl_rise = now_s[0] & ~old_s[0];
  assign scl_fall = ~now_s[0] & old_s[0];
  assign start    = now_s[0] & old_s[0] & old_s[1] & ~now_s[1];
  assign stop     = now_s[0] & old_s[0] & ~old_s[1] & now_s[1];
endmodule

// File: rtl/i2c_target.sv
// I2C responder emulating the IR camera register map: address match,
// pointer/data writes and auto-incrementing reads from a host-preloaded file.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = CAM_ADDR,
  parameter int         PTR_W    = 6
) (
  input logic         clk,
  input logic         reset,
  i2c_target_if.slave bus
);
  logic sda, scl_rise, scl_fall, start, stop;

  state_t           state_reg, state_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic [6:0]       shift_reg, shift_next;
  logic [6:0]       rd_shift_reg, rd_shift_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic             sda_oe_reg, sda_oe_next;
  logic             busy_reg, busy_next;
  logic             rw_reg, rw_next;
  logic             bus_wr_reg, bus_wr_next;
  logic [PTR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]       wr_data_reg, wr_data_next;
  logic             pend_v_reg, pend_v_next;
  logic [PTR_W-1:0] pend_addr_reg, pend_addr_next;
  logic [7:0]       pend_data_reg, pend_data_next;

  logic [7:0]       mem [2**PTR_W];
  logic             mem_we;
  logic [PTR_W-1:0] mem_addr;
  logic [7:0]       mem_wdata;
  logic [7:0]       rx_byte;
  logic [7:0]       rd_byte;

  i2c_line_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (bus.scl_in),
    .sda_in   (bus.sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign rx_byte = {shift_reg, sda};
  assign rd_byte = mem[ptr_reg];

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rd_shift_next = rd_shift_reg;
    ptr_next      = ptr_reg;
    sda_oe_next   = sda_oe_reg;
    busy_next     = busy_reg;
    rw_next       = rw_reg;
    bus_wr_next   = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    if (stop) begin
      state_next  = IDLE;
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
    end else if (start) begin
      state_next   = ADDR;
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
    end else begin
      unique case (state_reg)
        ADDR, PTR, WDATA: if (scl_rise) begin
          shift_next   = rx_byte[6:0];
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd7) begin
            bit_cnt_next = 4'd0;
            if (state_reg == ADDR) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_next = ACK_A;
                busy_next  = 1'b1;
                rw_next    = rx_byte[0];
              end else begin
                state_next = IGNORE;
              end
            end else if (state_reg == PTR) begin
              ptr_next   = rx_byte[PTR_W-1:0];
              state_next = ACK_P;
            end else begin
              bus_wr_next  = 1'b1;
              wr_addr_next = ptr_reg;
              wr_data_next = rx_byte;
              ptr_next     = ptr_reg + 1'b1;
              state_next   = ACK_W;
            end
          end
        end
        // First SCL fall starts the ACK pulse, the second one ends it.
        ACK_A, ACK_P, ACK_W: if (scl_fall) begin
          if (!sda_oe_reg) begin
            sda_oe_next = 1'b1;
          end else if (state_reg == ACK_A && rw_reg) begin
            rd_shift_next = rd_byte[6:0];
            sda_oe_next   = ~rd_byte[7];
            bit_cnt_next  = 4'd0;
            state_next    = RDATA;
          end else begin
            sda_oe_next = 1'b0;
            state_next  = (state_reg == ACK_A) ? PTR : WDATA;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_oe_next = 1'b0;
              state_next  = MACK;
            end else begin
              sda_oe_next   = ~rd_shift_reg[6];
              rd_shift_next = {rd_shift_reg[5:0], 1'b0};
            end
          end
        end
        // bit_cnt 8 = waiting for the initiator's bit, 9 = ACK seen.
        MACK: begin
          if (scl_rise && bit_cnt_reg == 4'd8) begin
            if (sda) begin
              state_next = IGNORE;
            end else begin
              ptr_next     = ptr_reg + 1'b1;
              bit_cnt_next = 4'd9;
            end
          end else if (scl_fall && bit_cnt_reg == 4'd9) begin
            rd_shift_next = rd_byte[6:0];
            sda_oe_next   = ~rd_byte[7];
            bit_cnt_next  = 4'd0;
            state_next    = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Single write port: bus > deferred host > host. A host write losing the
  // port to a bus write at another address is replayed on the next clk.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = bus.host_addr;
    mem_wdata      = bus.host_wdata;
    pend_v_next    = 1'b0;
    pend_addr_next = pend_addr_reg;
    pend_data_next = pend_data_reg;
    if (bus_wr_reg) begin
      mem_we    = 1'b1;
      mem_addr  = wr_addr_reg;
      mem_wdata = wr_data_reg;
      if (pend_v_reg && pend_addr_reg != wr_addr_reg) begin
        pend_v_next = 1'b1;
      end else if (bus.host_we && bus.host_addr != wr_addr_reg) begin
        pend_v_next    = 1'b1;
        pend_addr_next = bus.host_addr;
        pend_data_next = bus.host_wdata;
      end
    end else if (pend_v_reg) begin
      mem_we    = 1'b1;
      mem_addr  = pend_addr_reg;
      mem_wdata = pend_data_reg;
      if (bus.host_we) begin
        pend_v_next    = 1'b1;
        pend_addr_next = bus.host_addr;
        pend_data_next = bus.host_wdata;
      end
    end else begin
      mem_we = bus.host_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= '0;
      rd_shift_reg  <= '0;
      ptr_reg       <= '0;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      rw_reg        <= 1'b0;
      bus_wr_reg    <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      pend_v_reg    <= 1'b0;
      pend_addr_reg <= '0;
      pend_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      rd_shift_reg  <= rd_shift_next;
      ptr_reg       <= ptr_next;
      sda_oe_reg    <= sda_oe_next;
      busy_reg      <= busy_next;
      rw_reg        <= rw_next;
      bus_wr_reg    <= bus_wr_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      pend_v_reg    <= pend_v_next;
      pend_addr_reg <= pend_addr_next;
      pend_data_reg <= pend_data_next;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign bus.sda_oe      = sda_oe_reg;
  assign bus.busy        = busy_reg;
  assign bus.bus_wr      = bus_wr_reg;
  assign bus.bus_wr_addr = wr_addr_reg;
  assign bus.bus_wr_data = wr_data_reg;
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged initiator on an open-drain SDA.
`timescale 1ns/1ps
module tb_i2c_target;
  localparam int PTR_W = 6;
  localparam int Q     = 8;   // clk cycles per quarter SCL period

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic             h_we   = 1'b0;
  logic [PTR_W-1:0] h_addr = '0;
  logic [7:0]       h_data = '0;
  logic             c_we   = 1'b0;
  logic [PTR_W-1:0] c_addr = '0;
  logic [7:0]       c_data = '0;
  logic             collide_en   = 1'b0;
  logic             collide_same = 1'b0;
  int               c_cnt  = 0;
  logic             oe_seen = 1'b0;

  logic [PTR_W-1:0] wr_addr_q [$];
  logic [7:0]       wr_data_q [$];

  i2c_target_if #(.PTR_W(PTR_W)) bus ();

  i2c_target #(.DEV_ADDR(7'h58), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.scl_in     = scl_drv;
  assign bus.sda_in     = sda_drv & ~bus.sda_oe;
  assign bus.host_we    = h_we | c_we;
  assign bus.host_addr  = c_we ? c_addr : h_addr;
  assign bus.host_wdata = c_we ? c_data : h_data;

  // Log bus writes and any SDA drive; optionally collide a host write.
  always @(negedge clk) begin
    if (bus.bus_wr) begin
      wr_addr_q.push_back(bus.bus_wr_addr);
      wr_data_q.push_back(bus.bus_wr_data);
    end
    if (bus.sda_oe) oe_seen <= 1'b1;
    if (collide_en && bus.bus_wr) begin
      c_we   <= 1'b1;
      c_addr <= collide_same ? bus.bus_wr_addr : 6'h20;
      c_data <= collide_same ? 8'hEE : 8'h99;
      c_cnt  <= c_cnt + 1;
    end else begin
      c_we <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic put_bit(input logic b, output logic got);
    sda_drv = b;    qwait();
    scl_drv = 1'b1; qwait();
    got = bus.sda_in; qwait();
    scl_drv = 1'b0; qwait();
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; qwait();
    scl_drv = 1'b1; qwait();
    sda_drv = 1'b0; qwait();
    scl_drv = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; qwait();
    scl_drv = 1'b1; qwait();
    sda_drv = 1'b1; qwait();
    qwait();
  endtask

  task automatic send_chk(input string tag, input logic [7:0] b, input logic exp_ack);
    logic g;
    for (int i = 7; i >= 0; i--) put_bit(b[i], g);
    put_bit(1'b1, g);
    chk(tag, g, exp_ack);
  endtask

  task automatic recv_chk(input string tag, input logic nack, input logic [7:0] exp);
    logic       g;
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, g);
      b[i] = g;
    end
    put_bit(nack, g);
    chk(tag, b, exp);
  endtask

  task automatic host_wr(input logic [PTR_W-1:0] a, input logic [7:0] d);
    h_we = 1'b1; h_addr = a; h_data = d;
    @(negedge clk);
    h_we = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic [PTR_W-1:0] a, input logic [7:0] d);
    chk({tag, "_seen"}, wr_addr_q.size() != 0, 1);
    if (wr_addr_q.size() != 0) begin
      chk({tag, "_addr"}, wr_addr_q.pop_front(), a);
      chk({tag, "_data"}, wr_data_q.pop_front(), d);
    end
  endtask

  task automatic wr_one(input string tag, input logic [7:0] p, input logic [7:0] d);
    $display("txn %s write ptr=%02h data=%02h", tag, p, d);
    i2c_start();
    send_chk({tag, "_ackd"}, 8'hB0, 1'b0);
    send_chk({tag, "_ackp"}, p, 1'b0);
    send_chk({tag, "_ackw"}, d, 1'b0);
    i2c_stop();
  endtask

  task automatic read_one(input string tag, input logic [7:0] p, input logic [7:0] exp);
    $display("txn %s read ptr=%02h expect=%02h", tag, p, exp);
    i2c_start();
    send_chk({tag, "_ackd"}, 8'hB0, 1'b0);
    send_chk({tag, "_ackp"}, p, 1'b0);
    i2c_start();
    send_chk({tag, "_ackr"}, 8'hB1, 1'b0);
    recv_chk({tag, "_data"}, 1'b1, exp);
    i2c_stop();
  endtask

  initial begin
    repeat (5) @(negedge clk);
    $display("txn reset");
    chk("rst_oe",    bus.sda_oe,      0);
    chk("rst_busy",  bus.busy,        0);
    chk("rst_wr",    bus.bus_wr,      0);
    chk("rst_waddr", bus.bus_wr_addr, 0);
    chk("rst_wdata", bus.bus_wr_data, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("txn write B0 30 01");
    i2c_start();
    send_chk("w_ackd", 8'hB0, 1'b0);
    chk("w_busy", bus.busy, 1);
    send_chk("w_ackp", 8'h30, 1'b0);
    send_chk("w_ackw", 8'h01, 1'b0);
    i2c_stop();
    chk("w_busy_end", bus.busy, 0);
    chk("w_count", wr_addr_q.size(), 1);
    chk_wr("w", 6'h30, 8'h01);

    $display("txn read 36..38 with ACK ACK NACK");
    host_wr(6'h36, 8'hA5);
    host_wr(6'h37, 8'h5A);
    host_wr(6'h38, 8'hFF);
    i2c_start();
    send_chk("r_ackd", 8'hB0, 1'b0);
    send_chk("r_ackp", 8'h36, 1'b0);
    i2c_start();
    send_chk("r_ackr", 8'hB1, 1'b0);
    recv_chk("r_b0", 1'b0, 8'hA5);
    recv_chk("r_b1", 1'b0, 8'h5A);
    recv_chk("r_b2", 1'b1, 8'hFF);
    repeat (4) @(negedge clk);
    chk("r_release", bus.sda_oe, 0);
    i2c_stop();
    chk("r_nowr", wr_addr_q.size(), 0);

    $display("txn wrong address A0 and general call 00");
    oe_seen = 1'b0;
    i2c_start();
    send_chk("x_nack", 8'hA0, 1'b1);
    send_chk("x_nack2", 8'h5C, 1'b1);
    i2c_stop();
    i2c_start();
    send_chk("gc_nack", 8'h00, 1'b1);
    send_chk("gc_nack2", 8'h30, 1'b1);
    i2c_stop();
    chk("x_oe_never", oe_seen, 0);
    chk("x_nowr", wr_addr_q.size(), 0);
    chk("x_busy", bus.busy, 0);

    $display("txn wrap write ptr=3F data 11 22");
    i2c_start();
    send_chk("wr_ackd", 8'hB0, 1'b0);
    send_chk("wr_ackp", 8'h3F, 1'b0);
    send_chk("wr_ack0", 8'h11, 1'b0);
    send_chk("wr_ack1", 8'h22, 1'b0);
    i2c_stop();
    chk_wr("wrap0", 6'h3F, 8'h11);
    chk_wr("wrap1", 6'h00, 8'h22);

    collide_en   = 1'b1;
    collide_same = 1'b1;
    wr_one("cs", 8'h10, 8'h77);
    chk_wr("cs", 6'h10, 8'h77);
    collide_same = 1'b0;
    wr_one("cd", 8'h12, 8'h44);
    chk_wr("cd", 6'h12, 8'h44);
    collide_en = 1'b0;
    chk("c_hits", c_cnt, 2);
    read_one("cs_rd", 8'h10, 8'h77);
    read_one("cd_rd", 8'h12, 8'h44);
    read_one("ch_rd", 8'h20, 8'h99);

    $display("txn abort read of 00 with reset");
    host_wr(6'h05, 8'h00);
    i2c_start();
    send_chk("ab_ackd", 8'hB0, 1'b0);
    send_chk("ab_ackp", 8'h05, 1'b0);
    i2c_start();
    send_chk("ab_ackr", 8'hB1, 1'b0);
    chk("ab_drive", bus.sda_oe, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("ab_release", bus.sda_oe, 0);
    chk("ab_busy", bus.busy, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    i2c_start();
    send_chk("ab_reack", 8'hB0, 1'b0);
    i2c_stop();
    chk("ab_end_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
